// File: rtl/rf_seq.sv
// Serialises rs1/rs2 operand reads and rd writeback onto one single-port RF; optional RF_SEQ_SKIP_EN skips unneeded reads.
// Latency: rsp_valid three cycles after the accept cycle (one to three with RF_SEQ_SKIP_EN); writes complete in the cycle offered.
// Backpressure: rsp held stable until rsp_ready; writes stall only during RD1/RD2; reads wait while a write is offered in IDLE.
module rf_seq #(
    parameter int WORD_SIZE = 32,
    parameter int REG_COUNT = 32,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rs1_data,
    output logic [WORD_SIZE-1:0] rs2_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    input  logic [WORD_SIZE-1:0] rf_rdata
);

    typedef enum logic [1:0] {IDLE, RD1, RD2, RSP} state_t;

    state_t          state;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic            use1_q;
    logic            use2_q;
    logic            port_free;

`ifdef RF_SEQ_SKIP_EN
    function automatic logic needs_read(input logic u, input logic [AW-1:0] a);
        return u && (a != '0);
    endfunction
`endif

    // Gating on rst keeps the reset cycle free of writes and handshakes.
    always_comb begin
        port_free    = (state == IDLE) || (state == RSP);
        wr_ready     = port_free && !rst;
        rf_we        = wr_ready && wr_valid && (wr_addr != '0);
        rd_req_ready = (state == IDLE) && !wr_valid && !rst;
        rf_wdata     = wr_data;
        rf_addr      = wr_addr;
        if (state == RD1 && use1_q)
            rf_addr = rs1_q;
        else if (state == RD2 && use2_q)
            rf_addr = rs2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use1_q    <= 1'b0;
            use2_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req_valid && rd_req_ready) begin
                        rs1_q  <= rs1_addr;
                        rs2_q  <= rs2_addr;
                        use1_q <= use_rs1;
                        use2_q <= use_rs2;
`ifdef RF_SEQ_SKIP_EN
                        if (needs_read(use_rs1, rs1_addr)) begin
                            state <= RD1;
                        end else begin
                            rs1_data <= '0;
                            if (needs_read(use_rs2, rs2_addr)) begin
                                state <= RD2;
                            end else begin
                                rs2_data  <= '0;
                                state     <= RSP;
                                rsp_valid <= 1'b1;
                            end
                        end
`else
                        state <= RD1;
`endif
                    end
                end
                RD1: begin
                    rs1_data <= use1_q ? rf_rdata : '0;
`ifdef RF_SEQ_SKIP_EN
                    if (needs_read(use2_q, rs2_q)) begin
                        state <= RD2;
                    end else begin
                        rs2_data  <= '0;
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                    end
`else
                    state <= RD2;
`endif
                end
                RD2: begin
                    rs2_data  <= use2_q ? rf_rdata : '0;
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
